rice_core_id_stage: RTL

RICE_CORE_ID_STAGE -- requirements
Module: rice_core_id_stage

---
 rtl/rice_core_id_stage.sv | 185 ++++++++++++++++++
 1 files changed

// File: rtl/rice_core_id_stage.sv
// Decode stage: decodes ADDI/ADD/SUB/LUI, reads the register file, registers operands; optional macro RICE_CORE_WB_BYPASS_EN.
// Latency: one cycle from fetch handshake to o_id_valid.
// Backpressure: payload held while o_id_valid && !i_ex_ready; o_if_ready low then, and during flush/reset.
package rice_core_pkg;
    typedef enum logic [0:0] {
        RICE_CORE_ALU_ADD = 1'b0,
        RICE_CORE_ALU_SUB = 1'b1
    } rice_core_alu_command;

    typedef enum logic [1:0] {
        RICE_CORE_ALU_SOURCE_NONE = 2'd0,
        RICE_CORE_ALU_SOURCE_RS   = 2'd1,
        RICE_CORE_ALU_SOURCE_IMM  = 2'd2
    } rice_core_alu_source;

    typedef struct packed {
        rice_core_alu_command command;
        rice_core_alu_source  source_1;
        rice_core_alu_source  source_2;
    } rice_core_alu_operation;
endpackage

module rice_core_id_stage
    import rice_core_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic                   i_clk,
    input  logic                   i_rst,
    input  logic                   i_if_valid,
    output logic                   o_if_ready,
    input  logic [XLEN-1:0]        i_if_pc,
    input  logic [31:0]            i_if_inst,
    input  logic                   i_flush,
    output logic                   o_id_valid,
    input  logic                   i_ex_ready,
    output logic [XLEN-1:0]        o_id_pc,
    output logic [XLEN-1:0]        o_rs1_value,
    output logic [XLEN-1:0]        o_rs2_value,
    output logic [XLEN-1:0]        o_imm_value,
    output rice_core_alu_operation o_alu_operation,
    output logic [4:0]             o_rd,
    output logic                   o_rd_write,
    output logic                   o_illegal,
    input  logic                   i_wb_valid,
    input  logic [4:0]             i_wb_rd,
    input  logic [XLEN-1:0]        i_wb_value
);
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;

    logic [XLEN-1:0] regs [32];

    logic [6:0] opcode;
    logic [2:0] funct3;
    logic [6:0] funct7;
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic       capture;
    logic       wb_en;

    rice_core_alu_operation dec_op;
    logic [XLEN-1:0]        dec_imm;
    logic                   dec_write;
    logic                   dec_illegal;
    logic [XLEN-1:0]        rf_rs1;
    logic [XLEN-1:0]        rf_rs2;
    logic [XLEN-1:0]        cap_rs1;
    logic [XLEN-1:0]        cap_rs2;

    assign opcode  = i_if_inst[6:0];
    assign funct3  = i_if_inst[14:12];
    assign funct7  = i_if_inst[31:25];
    assign rs1     = i_if_inst[19:15];
    assign rs2     = i_if_inst[24:20];
    assign wb_en   = i_wb_valid && (i_wb_rd != 5'd0);

    assign o_if_ready = !i_rst && (!o_id_valid || i_ex_ready) && !i_flush;
    assign capture    = i_if_valid && o_if_ready;

    always_comb begin
        dec_op      = '{command: RICE_CORE_ALU_ADD,
                        source_1: RICE_CORE_ALU_SOURCE_NONE,
                        source_2: RICE_CORE_ALU_SOURCE_NONE};
        dec_imm     = '0;
        dec_write   = 1'b0;
        dec_illegal = 1'b1;
        case (opcode)
            OPC_OP_IMM: begin
                if (funct3 == 3'b000) begin
                    dec_op.source_1 = RICE_CORE_ALU_SOURCE_RS;
                    dec_op.source_2 = RICE_CORE_ALU_SOURCE_IMM;
                    dec_imm         = XLEN'($signed(i_if_inst[31:20]));
                    dec_write       = 1'b1;
                    dec_illegal     = 1'b0;
                end
            end
            OPC_OP: begin
                if (funct3 == 3'b000 && (funct7 == 7'b0000000 || funct7 == 7'b0100000)) begin
                    dec_op.command  = (funct7 == 7'b0100000) ? RICE_CORE_ALU_SUB : RICE_CORE_ALU_ADD;
                    dec_op.source_1 = RICE_CORE_ALU_SOURCE_RS;
                    dec_op.source_2 = RICE_CORE_ALU_SOURCE_RS;
                    dec_write       = 1'b1;
                    dec_illegal     = 1'b0;
                end
            end
            OPC_LUI: begin
                dec_op.source_2 = RICE_CORE_ALU_SOURCE_IMM;
                dec_imm         = XLEN'($signed({i_if_inst[31:12], 12'b0}));
                dec_write       = 1'b1;
                dec_illegal     = 1'b0;
            end
            default: ;
        endcase
    end

    // x0 is forced to zero on read as well as never being written
    assign rf_rs1 = (rs1 == 5'd0) ? '0 : regs[rs1];
    assign rf_rs2 = (rs2 == 5'd0) ? '0 : regs[rs2];

`ifdef RICE_CORE_WB_BYPASS_EN
    logic [4:0] held_rs1;
    logic [4:0] held_rs2;

    assign cap_rs1 = (wb_en && i_wb_rd == rs1) ? i_wb_value : rf_rs1;
    assign cap_rs2 = (wb_en && i_wb_rd == rs2) ? i_wb_value : rf_rs2;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            held_rs1 <= '0;
            held_rs2 <= '0;
        end else if (capture) begin
            held_rs1 <= rs1;
            held_rs2 <= rs2;
        end
    end
`else
    // Array reads see pre-write content, so a same-cycle writeback is not forwarded
    assign cap_rs1 = rf_rs1;
    assign cap_rs2 = rf_rs2;
`endif

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            for (int i = 0; i < 32; i++) regs[i] <= '0;
            o_id_valid      <= 1'b0;
            o_id_pc         <= '0;
            o_rs1_value     <= '0;
            o_rs2_value     <= '0;
            o_imm_value     <= '0;
            o_alu_operation <= '{command: RICE_CORE_ALU_ADD,
                                 source_1: RICE_CORE_ALU_SOURCE_NONE,
                                 source_2: RICE_CORE_ALU_SOURCE_NONE};
            o_rd            <= '0;
            o_rd_write      <= 1'b0;
            o_illegal       <= 1'b0;
        end else begin
            if (wb_en) regs[i_wb_rd] <= i_wb_value;

            if (i_flush) begin
                o_id_valid <= 1'b0;
            end else if (capture) begin
                o_id_valid      <= 1'b1;
                o_id_pc         <= i_if_pc;
                o_rs1_value     <= cap_rs1;
                o_rs2_value     <= cap_rs2;
                o_imm_value     <= dec_imm;
                o_alu_operation <= dec_op;
                o_rd            <= i_if_inst[11:7];
                o_rd_write      <= dec_write;
                o_illegal       <= dec_illegal;
            end else if (o_id_valid && i_ex_ready) begin
                o_id_valid <= 1'b0;
            end
`ifdef RICE_CORE_WB_BYPASS_EN
            else if (o_id_valid) begin
                // Stalled instruction tracks writebacks to its sources
                if (wb_en && i_wb_rd == held_rs1) o_rs1_value <= i_wb_value;
                if (wb_en && i_wb_rd == held_rs2) o_rs2_value <= i_wb_value;
            end
`endif
        end
    end
endmodule
